// File: rtl/henon_prng_stream.sv
// Fixed-point Henon-map PRNG: folds pixel bytes into a seed, warms up the map,
// then streams (x, y) samples over a valid/ready handshake.
module henon_prng_stream #(
  parameter int WIDTH        = 32,
  parameter int FRAC         = 24,
  parameter int TOTAL_PIXELS = 8,
  parameter int WARMUP       = 16,
  parameter int NUM_OUTPUTS  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [15:0]      seed_16,
  input  logic [7:0]       uart_pixel_in,
  input  logic             uart_pixel_valid,
  output logic [WIDTH-1:0] random_out_x,
  output logic [WIDTH-1:0] random_out_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done,
  output logic             reseed
);
  typedef enum logic [2:0] {IDLE, COLLECT, INIT, SQ, UPD, OUT, DONE} state_t;

  localparam int W2 = 2 * WIDTH;
  localparam logic [63:0] A64 = ((64'd14 << FRAC) + 64'd5) / 64'd10;
  localparam logic [63:0] B64 = ((64'd3 << FRAC) + 64'd5) / 64'd10;
  localparam logic signed [W2-1:0]    AE   = W2'(A64);
  localparam logic signed [W2-1:0]    BE   = W2'(B64);
  localparam logic signed [WIDTH-1:0] ONE  = WIDTH'(64'd1 << FRAC);
  localparam logic signed [WIDTH-1:0] LIM  = WIDTH'(64'd4 << FRAC);
  localparam logic signed [WIDTH-1:0] NLIM = -LIM;

  state_t state;
  logic signed [WIDTH-1:0] x, y, x0, sq;
  logic [31:0] ent, pix_cnt, warm, smp_cnt;
  logic pv_q;

  logic signed [W2-1:0]    xe, sqe;
  logic signed [WIDTH-1:0] sq_n, asq, xn, yn, x_nxt, y_nxt;
  logic [WIDTH-1:0]        x0_n;
  logic                    pix_edge, div;

  // Full-precision products; truncation back to WIDTH is the intended wrap.
  assign xe    = {{WIDTH{x[WIDTH-1]}}, x};
  assign sqe   = {{WIDTH{sq[WIDTH-1]}}, sq};
  assign sq_n  = WIDTH'((xe * xe) >>> FRAC);
  assign asq   = WIDTH'((sqe * AE) >>> FRAC);
  assign yn    = WIDTH'((xe * BE) >>> FRAC);
  assign xn    = ONE - asq + y;
  assign div   = (xn >= LIM) || (xn <= NLIM);
  assign x_nxt = div ? x0 : xn;
  assign y_nxt = div ? '0 : yn;
  assign x0_n  = WIDTH'(seed_16 ^ ent[15:0]) << (FRAC - 16);

  assign pix_edge = uart_pixel_valid & ~pv_q;
  assign busy     = (state != IDLE) && (state != DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      x            <= '0;
      y            <= '0;
      x0           <= '0;
      sq           <= '0;
      ent          <= '0;
      pix_cnt      <= '0;
      warm         <= '0;
      smp_cnt      <= '0;
      pv_q         <= 1'b0;
      random_out_x <= '0;
      random_out_y <= '0;
      out_valid    <= 1'b0;
      done         <= 1'b0;
      reseed       <= 1'b0;
    end else begin
      pv_q   <= uart_pixel_valid;
      reseed <= 1'b0;
      if (abort) begin
        state     <= IDLE;
        out_valid <= 1'b0;
        done      <= 1'b0;
      end else begin
        case (state)
          IDLE, DONE: if (start) begin
            ent     <= '0;
            pix_cnt <= '0;
            smp_cnt <= '0;
            done    <= 1'b0;
            state   <= (TOTAL_PIXELS == 0) ? INIT : COLLECT;
          end
          COLLECT: begin
            if (pix_cnt == 32'(TOTAL_PIXELS)) begin
              state <= INIT;
            end else if (pix_edge) begin
              ent     <= {ent[30:0], ent[31]} ^ {24'd0, uart_pixel_in};
              pix_cnt <= pix_cnt + 32'd1;
            end
          end
          INIT: begin
            x     <= x0_n;
            x0    <= x0_n;
            y     <= '0;
            warm  <= 32'(WARMUP);
            state <= SQ;
          end
          SQ: begin
            sq    <= sq_n;
            state <= UPD;
          end
          UPD: begin
            x      <= x_nxt;
            y      <= y_nxt;
            reseed <= div;
            if (warm != 32'd0) begin
              warm  <= warm - 32'd1;
              state <= SQ;
            end else begin
              state        <= OUT;
              out_valid    <= 1'b1;
              random_out_x <= x_nxt;
              random_out_y <= y_nxt;
            end
          end
          OUT: if (out_ready) begin
            out_valid <= 1'b0;
            smp_cnt   <= smp_cnt + 32'd1;
            if (NUM_OUTPUTS != 0 && smp_cnt + 32'd1 == 32'(NUM_OUTPUTS)) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= SQ;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
